// File: rtl/bpm_calculator.sv
// bpm_calculator
//   Consumer end of the beat-interval handshake. Captures a peak-to-peak
//   interval (in ticks) from the time-interval counter and converts it to
//   beats per minute with a 16-step restoring shift-subtract divider,
//   TICKS_PER_MIN / time_counter, truncated and clamped to 8 bits.
//   Each interval is acknowledged with a one-cycle BPMCalc_Done pulse.
//
// Optional feature: define BPM_AVG_EN to enable a 4-deep moving average of
//   the clamped results (adds an AVG state, latency 18 edges instead of 17).
//
// Ports:
//   clk           in   system clock, rising edge
//   rst           in   asynchronous active-high reset
//   time_counter  in   interval length in ticks (IW bits), stable while valid
//   valid         in   interval ready, held until BPMCalc_Done
//   BPMCalc_Done  out  one-cycle acknowledge to the counter
//   bpm           out  last computed BPM, holds between updates
//   bpm_valid     out  one-cycle pulse coincident with the bpm update
//   range_err     out  last result was saturated or had a zero interval
//   busy          out  high whenever the FSM is not in IDLE
module bpm_calculator #(
  parameter int TICKS_PER_MIN = 600,
  parameter int IW            = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [IW-1:0] time_counter,
  input  logic          valid,
  output logic          BPMCalc_Done,
  output logic [7:0]    bpm,
  output logic          bpm_valid,
  output logic          range_err,
  output logic          busy
);

  localparam logic [15:0] DIVIDEND = 16'(TICKS_PER_MIN);

  typedef enum logic [2:0] {S_IDLE, S_DIV, S_AVG, S_DONE, S_WAIT} state_t;

  state_t        r_state;
  logic [3:0]    r_cnt;
  logic          r_done;
  logic [7:0]    r_bpm;
  logic          r_bvld;
  logic          r_err;
  logic          r_busy;

  logic [IW-1:0] r_d;
  logic [IW-1:0] r_rem;
  logic [15:0]   r_dvd;
  logic [15:0]   r_quo;

  logic [IW:0]   w_trial;
  logic          w_ge;
  logic [IW-1:0] w_rem_nxt;
  logic          w_zero;
  logic          w_sat;
  logic [7:0]    w_raw;

  function automatic logic [7:0] clamp_bpm(input logic zero, input logic sat,
                                           input logic [7:0] q_lo);
    if (zero)     return 8'd0;
    else if (sat) return 8'hFF;
    else          return q_lo;
  endfunction

  // Trial remainder is IW+1 (7) bits; the kept remainder is always below d,
  // so the subtraction only needs the low IW bits.
  assign w_trial   = {r_rem, r_dvd[15]};
  assign w_ge      = (w_trial >= {1'b0, r_d});
  assign w_rem_nxt = w_ge ? (w_trial[IW-1:0] - r_d) : w_trial[IW-1:0];

  assign w_zero = (r_d == '0);
  assign w_sat  = |r_quo[15:8];
  assign w_raw  = clamp_bpm(w_zero, w_sat, r_quo[7:0]);

`ifdef BPM_AVG_EN
  logic [7:0] r_h0, r_h1, r_h2, r_h3;
  logic [2:0] r_hcnt;
  logic [9:0] w_sum;
  logic [7:0] w_avg;

  assign w_sum = 10'(r_h0) + 10'(r_h1) + 10'(r_h2) + 10'(r_h3);
  assign w_avg = 8'(w_sum >> 2);
`endif

  // Datapath: divisor, dividend, remainder, quotient (and history); no reset.
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && valid) begin
      r_d   <= time_counter;
      r_dvd <= DIVIDEND;
      r_rem <= '0;
      r_quo <= '0;
    end else if (r_state == S_DIV) begin
      r_dvd <= {r_dvd[14:0], 1'b0};
      r_rem <= w_rem_nxt;
      r_quo <= {r_quo[14:0], w_ge};
    end
`ifdef BPM_AVG_EN
    // Zero-interval results are kept out of the history.
    if (r_state == S_AVG && !w_zero) begin
      r_h3 <= r_h2;
      r_h2 <= r_h1;
      r_h1 <= r_h0;
      r_h0 <= w_raw;
    end
`endif
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_bpm   <= '0;
      r_bvld  <= 1'b0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
`ifdef BPM_AVG_EN
      r_hcnt  <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      r_bvld <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (valid) begin
            r_state <= S_DIV;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        S_DIV: begin
          r_cnt <= r_cnt + 4'd1;
          if (r_cnt == 4'd15) begin
`ifdef BPM_AVG_EN
            r_state <= S_AVG;
`else
            r_state <= S_DONE;
`endif
          end
        end
`ifdef BPM_AVG_EN
        S_AVG: begin
          if (!w_zero && r_hcnt != 3'd4) r_hcnt <= r_hcnt + 3'd1;
          r_state <= S_DONE;
        end
`endif
        S_DONE: begin
`ifdef BPM_AVG_EN
          // History count already includes this result when non-zero.
          if (w_zero)              r_bpm <= 8'd0;
          else if (r_hcnt == 3'd4) r_bpm <= w_avg;
          else                     r_bpm <= w_raw;
`else
          r_bpm <= w_raw;
`endif
          r_err   <= w_zero | w_sat;
          r_done  <= 1'b1;
          r_bvld  <= 1'b1;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          // Only a low valid re-arms capture: one computation per interval.
          if (!valid) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign BPMCalc_Done = r_done;
  assign bpm          = r_bpm;
  assign bpm_valid    = r_bvld;
  assign range_err    = r_err;
  assign busy         = r_busy;

endmodule

// File: tb/tb_bpm_calculator.sv
// Testbench for bpm_calculator: directed handshake/boundary steps followed by
// randomized intervals, checked against an arithmetic reference model.
module tb_bpm_calculator;

  localparam int IW  = 6;
  localparam int TPM = 600;
`ifdef BPM_AVG_EN
  localparam int LAT = 18;
`else
  localparam int LAT = 17;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [IW-1:0] time_counter;
  logic          valid;
  logic          BPMCalc_Done;
  logic [7:0]    bpm;
  logic          bpm_valid;
  logic          range_err;
  logic          busy;

  int checks = 0;
  int errors = 0;
  int hist[$];
  int last_bpm = 0;

  bpm_calculator #(.TICKS_PER_MIN(TPM), .IW(IW)) dut (
    .clk          (clk),
    .rst          (rst),
    .time_counter (time_counter),
    .valid        (valid),
    .BPMCalc_Done (BPMCalc_Done),
    .bpm          (bpm),
    .bpm_valid    (bpm_valid),
    .range_err    (range_err),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: BPM = TPM / interval, truncated, clamped to 255; zero interval
  // gives 0 with error. Optional 4-result moving average over valid results.
  task automatic model(input int tc, output int eb, output int ee);
    int q, raw, sum;
    if (tc == 0) begin
      eb = 0;
      ee = 1;
    end else begin
      q   = TPM / tc;
      raw = (q > 255) ? 255 : q;
      ee  = (q > 255) ? 1 : 0;
      eb  = raw;
`ifdef BPM_AVG_EN
      hist.push_back(raw);
      if (hist.size() > 4) void'(hist.pop_front());
      if (hist.size() == 4) begin
        sum = 0;
        foreach (hist[i]) sum += hist[i];
        eb = sum / 4;
      end
`endif
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_done"},      BPMCalc_Done, 0);
    chk({tag, "_bpm"},       bpm,          0);
    chk({tag, "_bpm_valid"}, bpm_valid,    0);
    chk({tag, "_range_err"}, range_err,    0);
    chk({tag, "_busy"},      busy,         0);
  endtask

  task automatic full_reset();
    @(negedge clk);
    rst = 1'b1;
    valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
    hist.delete();
    last_bpm = 0;
  endtask

  task automatic run_interval(input int tc, input int hold);
    int eb, ee, lat, extra;
    @(negedge clk);
    time_counter = IW'(tc);
    valid = 1'b1;
    @(posedge clk);               // E0: capture
    #1;
    chk("busy_after_capture", busy, 1);
    time_counter = IW'($urandom); // must be ignored after capture
    lat = 0;
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      @(posedge clk);
      #1;
      if (BPMCalc_Done === 1'b1) lat = k;
    end
    model(tc, eb, ee);
    chk("ack_latency", lat, LAT);
    chk("bpm_value", bpm, eb);
    chk("range_err", range_err, ee);
    chk("bpm_valid_pulse", bpm_valid, 1);
    extra = 0;
    for (int i = 0; i < hold + 1; i++) begin
      @(posedge clk);
      #1;
      if (BPMCalc_Done !== 1'b0 || bpm_valid !== 1'b0) extra++;
    end
    chk("single_ack", extra, 0);
    @(negedge clk);
    valid = 1'b0;
    @(posedge clk);
    #1;
    chk("busy_back_idle", busy, 0);
    chk("bpm_holds", bpm, eb);
    last_bpm = eb;
  endtask

  initial begin
    int n_ack;
    rst = 1'b1;
    valid = 1'b0;
    time_counter = '0;

    full_reset();

    // Directed values and boundaries
    run_interval(20, 0);
    run_interval(7, 0);
    run_interval(1, 0);
    run_interval(0, 0);
    run_interval(63, 0);

    // valid held long after the ack, then a fresh interval after a low cycle
    run_interval(20, 10);
    run_interval(15, 0);

    // Reset in the middle of the divide
    @(negedge clk);
    time_counter = IW'(20);
    valid = 1'b1;
    @(posedge clk);
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_reset_outputs("mid_div_rst");
    @(negedge clk);
    rst = 1'b0;
    valid = 1'b0;
    hist.delete();
    n_ack = 0;
    repeat (25) begin
      @(posedge clk);
      #1;
      if (BPMCalc_Done !== 1'b0) n_ack++;
    end
    chk("no_ack_after_abort", n_ack, 0);
    run_interval(12, 0);

    // Averaging sequence from a clean history
    full_reset();
    run_interval(10, 0);
    run_interval(12, 0);
    run_interval(15, 0);
    run_interval(20, 0);
    run_interval(0, 0);
    run_interval(30, 2);

    // Randomized intervals and hold times
    for (int r = 0; r < 25; r++) begin
      run_interval(int'($urandom_range(0, (1 << IW) - 1)), int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
